// File: rtl/cmp_pkg.sv
// Shared constants and types for the shared-comparator arbiter.
package cmp_pkg;

   localparam int unsigned CMP_WIDTH = 18;
   localparam int unsigned CMP_N_REQ = 4;

   typedef enum logic [1:0] {
      CMP_BELOW,
      CMP_EQUAL,
      CMP_ABOVE
   } cmp_res_t;

endpackage

// File: rtl/cmp_core.sv
// Combinational magnitude comparator with signed/unsigned mode and one-hot result.
module cmp_core
   import cmp_pkg::*;
#(
   parameter int unsigned WIDTH = CMP_WIDTH
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             is_signed_i,
   output logic             above_o,
   output logic             equal_o,
   output logic             below_o
);

   logic [WIDTH-1:0] a_x;
   logic [WIDTH-1:0] b_x;
   cmp_res_t         res;

   // Inverting the sign bit maps two's-complement order onto natural order.
   always_comb begin
      a_x            = a_i;
      b_x            = b_i;
      a_x[WIDTH-1]   = a_i[WIDTH-1] ^ is_signed_i;
      b_x[WIDTH-1]   = b_i[WIDTH-1] ^ is_signed_i;
      if (a_x == b_x) begin
         res = CMP_EQUAL;
      end else if (a_x > b_x) begin
         res = CMP_ABOVE;
      end else begin
         res = CMP_BELOW;
      end
   end

   assign above_o = (res == CMP_ABOVE);
   assign equal_o = (res == CMP_EQUAL);
   assign below_o = (res == CMP_BELOW);

endmodule

// File: rtl/cmp_arbiter.sv
// Round-robin arbiter feeding one shared comparator through a two-stage pipeline.
module cmp_arbiter
   import cmp_pkg::*;
#(
   parameter int unsigned WIDTH = CMP_WIDTH,
   parameter int unsigned N_REQ = CMP_N_REQ,
   parameter int unsigned ID_W  = $clog2(N_REQ)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   flush_i,
   input  logic [N_REQ-1:0]       req_i,
   input  logic [N_REQ*WIDTH-1:0] a_i,
   input  logic [N_REQ*WIDTH-1:0] b_i,
   input  logic [N_REQ-1:0]       signed_i,
   output logic [N_REQ-1:0]       gnt_o,
   output logic                   rsp_valid_o,
   output logic [ID_W-1:0]        rsp_id_o,
   output logic                   rsp_above_o,
   output logic                   rsp_equal_o,
   output logic                   rsp_below_o
);

   localparam logic [ID_W:0] NREQ_W = (ID_W+1)'(N_REQ);

   logic [ID_W-1:0]  ptr_q, ptr_d;
   logic [ID_W:0]    sum;
   logic [ID_W-1:0]  win;
   logic             found;
   logic             accept;

   logic             s1_v_q, s1_sgn_q, s1_sgn_d;
   logic [WIDTH-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
   logic [ID_W-1:0]  s1_id_q;

   logic             s2_v_q, s2_v_d;
   logic             s2_above_q, s2_equal_q, s2_below_q;
   logic [ID_W-1:0]  s2_id_q;

   logic             core_above, core_equal, core_below;

   always_comb begin
      found = 1'b0;
      win   = '0;
      sum   = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         sum = {1'b0, ptr_q} + (ID_W+1)'(i);
         if (sum >= NREQ_W) begin
            sum = sum - NREQ_W;
         end
         if (!found && req_i[sum[ID_W-1:0]]) begin
            found = 1'b1;
            win   = sum[ID_W-1:0];
         end
      end
   end

   assign accept = found & ~flush_i & rst_n;
   assign gnt_o  = accept ? (N_REQ'(1) << win) : '0;

   always_comb begin
      ptr_d = ptr_q;
      if (accept) begin
         ptr_d = (win == ID_W'(N_REQ-1)) ? '0 : win + ID_W'(1);
      end
   end

   always_comb begin
      s1_a_d   = '0;
      s1_b_d   = '0;
      s1_sgn_d = 1'b0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         if (win == ID_W'(k)) begin
            s1_a_d   = a_i[k*WIDTH +: WIDTH];
            s1_b_d   = b_i[k*WIDTH +: WIDTH];
            s1_sgn_d = signed_i[k];
         end
      end
   end

   cmp_core #(
      .WIDTH(WIDTH)
   ) u_core (
      .a_i        (s1_a_q),
      .b_i        (s1_b_q),
      .is_signed_i(s1_sgn_q),
      .above_o    (core_above),
      .equal_o    (core_equal),
      .below_o    (core_below)
   );

   assign s2_v_d = s1_v_q & ~flush_i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q      <= '0;
         s1_v_q     <= 1'b0;
         s1_a_q     <= '0;
         s1_b_q     <= '0;
         s1_sgn_q   <= 1'b0;
         s1_id_q    <= '0;
         s2_v_q     <= 1'b0;
         s2_above_q <= 1'b0;
         s2_equal_q <= 1'b0;
         s2_below_q <= 1'b0;
         s2_id_q    <= '0;
      end else begin
         ptr_q      <= ptr_d;
         s1_v_q     <= accept;
         if (accept) begin
            s1_a_q   <= s1_a_d;
            s1_b_q   <= s1_b_d;
            s1_sgn_q <= s1_sgn_d;
            s1_id_q  <= win;
         end
         s2_v_q     <= s2_v_d;
         s2_above_q <= core_above & s2_v_d;
         s2_equal_q <= core_equal & s2_v_d;
         s2_below_q <= core_below & s2_v_d;
         if (s2_v_d) begin
            s2_id_q <= s1_id_q;
         end
      end
   end

   // A flush also hides the result already sitting in stage 2 during the flush cycle.
   assign rsp_valid_o = s2_v_q & ~flush_i;
   assign rsp_above_o = s2_above_q & ~flush_i;
   assign rsp_equal_o = s2_equal_q & ~flush_i;
   assign rsp_below_o = s2_below_q & ~flush_i;
   assign rsp_id_o    = s2_id_q;

endmodule

// File: tb/tb_cmp_arbiter.sv
// Scoreboard bench for cmp_arbiter: directed requests, queued expectations, negedge monitor.
module tb_cmp_arbiter;

   localparam int W = 18;
   localparam int N = 4;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           flush_i;
   logic [N-1:0]   req_i;
   logic [N*W-1:0] a_i;
   logic [N*W-1:0] b_i;
   logic [N-1:0]   signed_i;
   logic [N-1:0]   gnt_o;
   logic           rsp_valid_o;
   logic [1:0]     rsp_id_o;
   logic           rsp_above_o;
   logic           rsp_equal_o;
   logic           rsp_below_o;

   typedef struct packed {
      logic [1:0] id;
      logic [2:0] flags;
   } exp_t;

   localparam logic [2:0] ABOVE = 3'b100;
   localparam logic [2:0] EQUAL = 3'b010;
   localparam logic [2:0] BELOW = 3'b001;

   exp_t       sb[$];
   logic [2:0] exp_flags [N];
   int         checks   = 0;
   int         failures = 0;

   cmp_arbiter #(
      .WIDTH(W),
      .N_REQ(N)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush_i    (flush_i),
      .req_i      (req_i),
      .a_i        (a_i),
      .b_i        (b_i),
      .signed_i   (signed_i),
      .gnt_o      (gnt_o),
      .rsp_valid_o(rsp_valid_o),
      .rsp_id_o   (rsp_id_o),
      .rsp_above_o(rsp_above_o),
      .rsp_equal_o(rsp_equal_o),
      .rsp_below_o(rsp_below_o)
   );

   always #5 clk = ~clk;

   function automatic logic [1:0] onehot_idx(input logic [N-1:0] g);
      logic [1:0] r = '0;
      for (int i = 0; i < N; i++) begin
         if (g[i]) r = 2'(i);
      end
      return r;
   endfunction

   task automatic set_ops(input int k, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s, input logic [2:0] flags);
      a_i[k*W +: W] = a;
      b_i[k*W +: W] = b;
      signed_i[k]   = s;
      exp_flags[k]  = flags;
   endtask

   task automatic issue(input logic [N-1:0] req, input logic [N-1:0] exp_gnt, input logic fl);
      exp_t e;
      @(posedge clk);
      #1;
      req_i   = req;
      flush_i = fl;
      if (fl) sb.delete();
      @(negedge clk);
      checks++;
      if (gnt_o !== exp_gnt) begin
         failures++;
         $display("FAIL gnt req=%b got=%b expected=%b", req, gnt_o, exp_gnt);
      end
      if (exp_gnt != '0) begin
         e.id    = onehot_idx(exp_gnt);
         e.flags = exp_flags[e.id];
         sb.push_back(e);
      end
   endtask

   task automatic check_quiet(input string name);
      checks++;
      if ({gnt_o, rsp_valid_o, rsp_id_o, rsp_above_o, rsp_equal_o, rsp_below_o} !== '0) begin
         failures++;
         $display("FAIL %s gnt=%b valid=%b id=%0d flags=%b%b%b expected all zero", name,
                  gnt_o, rsp_valid_o, rsp_id_o, rsp_above_o, rsp_equal_o, rsp_below_o);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         checks++;
         if (rsp_valid_o) begin
            if (sb.size() == 0) begin
               failures++;
               $display("FAIL unexpected_rsp got id=%0d flags=%b%b%b expected no response",
                        rsp_id_o, rsp_above_o, rsp_equal_o, rsp_below_o);
            end else begin
               e = sb.pop_front();
               if ({rsp_id_o, rsp_above_o, rsp_equal_o, rsp_below_o} !== {e.id, e.flags}) begin
                  failures++;
                  $display("FAIL rsp got id=%0d flags=%b%b%b expected id=%0d flags=%b",
                           rsp_id_o, rsp_above_o, rsp_equal_o, rsp_below_o, e.id, e.flags);
               end
            end
         end else if ({rsp_above_o, rsp_equal_o, rsp_below_o} !== 3'b000) begin
            failures++;
            $display("FAIL idle_flags got=%b%b%b expected=000",
                     rsp_above_o, rsp_equal_o, rsp_below_o);
         end
      end
   end

   initial begin
      #100000;
      failures++;
      $display("FAIL watchdog simulation did not complete in time");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n    = 1'b0;
      flush_i  = 1'b0;
      req_i    = '0;
      a_i      = '0;
      b_i      = '0;
      signed_i = '0;
      for (int k = 0; k < N; k++) exp_flags[k] = 3'b000;
      #1;
      check_quiet("reset_outputs");
      #11;
      rst_n = 1'b1;

      // single unsigned request, 5 vs 3
      set_ops(0, 18'd5, 18'd3, 1'b0, ABOVE);
      issue(4'b0001, 4'b0001, 1'b0);
      issue(4'b0000, 4'b0000, 1'b0);
      issue(4'b0000, 4'b0000, 1'b0);

      // signed vs unsigned; ptr is 1
      set_ops(1, 18'h3FFFF, 18'h00001, 1'b1, BELOW);
      set_ops(2, 18'h3FFFF, 18'h00001, 1'b0, ABOVE);
      set_ops(3, 18'h20000, 18'h20000, 1'b1, EQUAL);
      set_ops(0, 18'h20000, 18'h20000, 1'b0, EQUAL);
      issue(4'b0010, 4'b0010, 1'b0);
      issue(4'b0100, 4'b0100, 1'b0);
      issue(4'b1000, 4'b1000, 1'b0);
      issue(4'b0001, 4'b0001, 1'b0);
      issue(4'b1000, 4'b1000, 1'b0);

      // all four held for 8 cycles from ptr 0
      for (int c = 0; c < 8; c++) begin
         logic [N-1:0] g;
         g = 4'b0001 << (c % 4);
         issue(4'b1111, g, 1'b0);
      end

      // wrap and skip after last grant to 3
      issue(4'b0101, 4'b0001, 1'b0);
      issue(4'b0101, 4'b0100, 1'b0);
      issue(4'b1000, 4'b1000, 1'b0);
      issue(4'b1000, 4'b1000, 1'b0);

      // flush with both stages full and a pending request; ptr is 3 at flush
      issue(4'b0010, 4'b0010, 1'b0);
      issue(4'b0100, 4'b0100, 1'b0);
      issue(4'b1111, 4'b0000, 1'b1);
      issue(4'b0000, 4'b0000, 1'b0);
      issue(4'b0000, 4'b0000, 1'b0);
      issue(4'b1111, 4'b1000, 1'b0);
      issue(4'b0000, 4'b0000, 1'b0);
      issue(4'b0000, 4'b0000, 1'b0);
      issue(4'b0000, 4'b0000, 1'b0);

      // asynchronous reset mid-stream with a result on the outputs
      issue(4'b1111, 4'b0001, 1'b0);
      issue(4'b1111, 4'b0010, 1'b0);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      req_i = '0;
      sb.delete();
      #1;
      check_quiet("async_reset");
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      issue(4'b1111, 4'b0001, 1'b0);
      issue(4'b0000, 4'b0000, 1'b0);
      issue(4'b0000, 4'b0000, 1'b0);
      issue(4'b0000, 4'b0000, 1'b0);

      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL drain pending=%0d expected=0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cmp_arbiter.md
# cmp_arbiter

Round-robin arbiter and two-stage pipeline that shares one 18-bit magnitude comparator among several requesters (branch-condition logic, ALU compare ops, min/max helpers). Each requester presents two operands and a signed/unsigned mode. The block grants one requester per cycle, registers its operands into the shared comparator, and returns a one-hot above/equal/below result tagged with the requester index. It sits between the issuing units and the single comparator datapath, replacing per-unit comparators.

## Interface
- `WIDTH`, 18, operand width.
- `N_REQ`, 4, number of requesters (2..8).
- `ID_W`, `$clog2(N_REQ)`, width of the requester index.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `flush_i` input 1: synchronous pipeline flush.
- `req_i` input N_REQ: per-requester request.
- `a_i` input N_REQ*WIDTH: operand A; slice i belongs to requester i.
- `b_i` input N_REQ*WIDTH: operand B; slice i belongs to requester i.
- `signed_i` input N_REQ: per-requester mode (1 = two's-complement compare).
- `gnt_o` output N_REQ: one-hot grant, combinational, same cycle as the accepted request.
- `rsp_valid_o` output 1: result valid for one cycle.
- `rsp_id_o` output ID_W: index of the requester that owns the result.
- `rsp_above_o`, `rsp_equal_o`, `rsp_below_o` output 1 each: comparison of A with B.

## Operation
- Handshake:
  - A request is accepted in a cycle where `req_i[k]` and `gnt_o[k]` are both 1.
  - The operands and mode are sampled on that edge.
  - The requester may drop the request, or present a new one, in the following cycle.
  - An unchanged `req_i` in the next cycle is a new request.
- Arbitration:
  - Round-robin with a rotating pointer `ptr` in 0..N_REQ-1; reset value 0.
  - The winner is the first asserted `req_i` searching ptr, ptr+1, … with modulo wrap.
  - On a grant, `ptr <= (winner+1) mod N_REQ`. With no grant, `ptr` holds.
- `gnt_o` is all-zero when no request is pending, when `flush_i=1`, and during reset.
- Stage 1 register: op_a, op_b, mode, id, and valid s1_v.
- Stage 2 register: result flags, id, and valid, which drives the outputs.
- Compare:
  - Unsigned mode compares the operands as natural numbers.
  - Signed mode treats bit WIDTH-1 as the sign.
  - Exactly one flag is 1 whenever `rsp_valid_o=1`.
  - All three flags are 0 whenever `rsp_valid_o=0`.
- No backpressure: a result is presented for exactly one cycle and is not held.
- Flush:
  - Clears both stage valids on the edge.
  - Suppresses `gnt_o` in that cycle.
  - Does not change `ptr`.
  - Any in-flight result is discarded and never reported.
- Reset:
  - Takes effect asynchronously: all valids 0, all flags 0, `rsp_id_o=0`, `ptr=0`.
  - Operations in flight are lost. Requesters re-issue them after reset.

## Timing
- Grant and acceptance happen in cycle t.
- The comparison is evaluated in cycle t+1 on the stage-1 registers.
- `rsp_valid_o` and the flags are asserted in cycle t+2. Latency is 2 cycles.
- Throughput is one compare per cycle, shared across all requesters.
- The compare and grant paths are independent: a grant in cycle t+1 does not disturb the result of the grant from cycle t.
- Flush at cycle t:
  - The op accepted at t-1 gives no response at t+1.
  - The op accepted at t-2 gives no response at t.
  - A request at t is not granted.
- Reset outputs: `gnt_o=0`, `rsp_valid_o=0`, `rsp_id_o=0`, and all flags 0.

## Structure
- Package `cmp_pkg`:
  - Constant `CMP_WIDTH=18`.
  - Default `CMP_N_REQ=4`.
  - Enum `cmp_res_t` {CMP_BELOW, CMP_EQUAL, CMP_ABOVE}, used internally before one-hot decode.
- Sub-module `cmp_core`:
  - Purely combinational.
  - Inputs a, b, is_signed; outputs the three one-hot flags.
  - Instantiated once, between stage 1 and stage 2.
- Arbiter, pointer, and pipeline registers live in `cmp_arbiter`.

## Test plan
- Single unsigned request, `req_i=0001`, A=5, B=3:
  - `gnt_o=0001` in the same cycle.
  - Two cycles later: `rsp_valid_o=1`, `rsp_id_o=0`, above=1.
- Signed vs unsigned, A=18'h3FFFF, B=18'h00001:
  - With signed_i=1: below=1.
  - Same operands, unsigned: above=1.
  - A=B=18'h20000: equal=1 in both modes.
- All four requesters held high for 8 cycles:
  - Grants are 0,1,2,3,0,1,2,3 in consecutive cycles.
  - `rsp_id_o` follows the same sequence, delayed by 2 cycles, with no gaps.
- Wrap and skip, last grant to requester 3, then `req_i=0101`:
  - Grant goes to 0, then to 2 on the next cycle.
  - With `req_i=1000` after a grant to 3, 3 is granted again.
- Flush with ops in both stages plus a pending request:
  - `gnt_o=0` during the flush cycle.
  - No `rsp_valid_o` for the next 2 cycles.
  - `ptr` is unchanged.
- Assert `rst_n=0` mid-stream between clock edges:
  - Outputs go to 0 immediately.
  - After release with `req_i=1111`, the first grant is requester 0.
